pixel_gamma_stage: RTL
======================

// Module: pixel_gamma_stage
// PURPOSE
//   Read-side pixel conditioner between the double-buffered frame memory and the panel scan driver.
//   Takes each 24-bit pixel read for scan-out and applies an optional per-channel gamma curve.
//   Then scales every channel by a global brightness that fades frame-by-frame toward a target.
//   Fixed 2-cycle pipeline. The scan driver's memory read latency must include these 2 cycles.
// PARAMETERS
//   CHANNEL_BITS  8    bits per colour channel; pixel width is 3*CHANNEL_BITS
//   BRIGHT_RESET  255  brightness loaded into current and target on reset
// PORTS
//   clk           in   1    system clock
//   rst           in   1    synchronous, active-high reset
//   in_valid      in   1    pixel_in is a scan-out read
//   pixel_in      in   24   {B[23:16],G[15:8],R[7:0]} from frame memory
//   frame_complete in  1    1-cycle pulse from scan driver at end of frame
//   bright_wr     in   1    latch bright_target/bright_step
//   bright_target in   8    requested brightness, 0=off, 255=full
//   bright_step   in   4    fade increment per frame; 0 = jump immediately
//   out_valid     out  1    pixel_out valid (in_valid delayed 2)
//   pixel_out     out  24   conditioned pixel, same channel order
//   bright_cur    out  8    brightness currently applied
//   fading        out  1    high while bright_cur != latched target
// BEHAVIOUR
// - Reset: out_valid=0, pixel_out=0, bright_cur=target=BRIGHT_RESET, step=0, fading=0. Pipeline contents discarded.
// - Stage 1 (reg): per channel c1 = GAMMA(c) with GAMMA_LUT_EN, else c1 = c; valid1 <= in_valid.
// - Stage 2 (reg): out = (c1 * (bright_cur+1)) >> 8, 16-bit product, no rounding.
//   brightness 255 -> identity; 0 -> all channels 0.
// - Latency exactly 2 cycles, no stalls, no backpressure. A new pixel is accepted every cycle.
// - pixel_out holds its last value when out_valid=0.
// - bright_cur is sampled by stage 2. It changes only on the cycle after frame_complete, never mid-frame.
// - bright_wr: target/step registered next edge. Takes effect at the next frame_complete, not before.
// - Fade FSM states IDLE (cur==target) and RAMP (cur!=target), fading = (state==RAMP). On frame_complete:
//     step==0             -> cur = target
//     cur<target          -> cur = min(cur+step, target)  (9-bit compare, no wrap past 255)
//     cur>target          -> cur = max(cur-step, target)  (no wrap below 0)
// - Simultaneous bright_wr and frame_complete: the fade step uses the previously latched target/step.
//   The new values are latched and apply from the following frame.
// - Target rewritten during RAMP: the ramp continues from the current bright_cur toward the new target, with no jump.
// - rst mid-frame or mid-fade: everything returns to its reset value on the next edge.
// CONFIGURATION
// - GAMMA_LUT_EN defined: one 256x8 gamma ROM (gamma 2.2, entry 0 -> 0, entry 255 -> 255), shared curve.
//   It is read combinationally per channel and registered in stage 1.
// - GAMMA_LUT_EN undefined: stage 1 is a plain register, no ROM is inferred, and latency is still 2.
// STRUCTURE
// - display_pkg: CHANNEL_BITS, PIXEL_BITS, channel slice offsets (R_LSB/G_LSB/B_LSB), fade state encoding.
// - Sub-module gamma_lut: 8-bit address to 8-bit data, combinational ROM.
//   It is instantiated 3x only under GAMMA_LUT_EN.
// - Fade FSM and the multiply pipeline are kept in this module.
// TESTING
// - Passthrough: reset, in_valid with pixel 0x80FF01 -> out_valid after 2 cycles, pixel_out 0x80FF01 (macro off).
// - Scale: bright_wr target=127 step=0, pulse frame_complete, send 0xFFFFFF -> pixel_out 0x7F7F7F.
//   Before the pulse, output is still 0xFFFFFF.
// - Fade down: target=0 step=4 from 255 -> bright_cur 251,247,... after each frame_complete.
//   Reaches exactly 0 after 64 frames (clamped); fading drops the cycle after it reaches 0.
// - Fade up with overshoot: cur=250, target=255, step=15 -> one frame_complete gives 255 (no wrap to 9), fading=0.
// - Collision: bright_wr(target=0,step=0) in the same cycle as frame_complete -> cur unchanged.
//   The next frame_complete sets it to 0.
// - Gamma (macro on): pixel 0x000000 -> 0x000000; 0xFFFFFF -> 0xFFFFFF; R=0x80 -> R=0x37.
//   Then rst mid-stream -> out_valid=0 next cycle, bright_cur=255.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display-path constants: channel geometry, brightness widths, fade state encoding.
// Also holds the gamma 2.2 curve generator used to build the ROM contents at elaboration.
package display_pkg;

   localparam int CHANNEL_BITS = 8;
   localparam int PIXEL_BITS   = 3 * CHANNEL_BITS;
   localparam int R_LSB        = 0;
   localparam int G_LSB        = CHANNEL_BITS;
   localparam int B_LSB        = 2 * CHANNEL_BITS;
   localparam int BRIGHT_BITS  = 8;
   localparam int STEP_BITS    = 4;

   localparam logic [0:0] FADE_IDLE = 1'b0;
   localparam logic [0:0] FADE_RAMP = 1'b1;

   // Truncates rather than rounds, so mid-scale 0x80 maps to 0x37.
   function automatic logic [7:0] gamma_entry(input int idx);
      real x;
      x = $pow(real'(idx) / 255.0, 2.2) * 255.0;
      return 8'($rtoi(x));
   endfunction

endpackage

// File: rtl/gamma_lut.sv
// Gamma 2.2 lookup: 256x8 combinational ROM, zero latency, no flow control.
// Contents are elaboration-time constants; only used when GAMMA_LUT_EN is defined.
module gamma_lut
   import display_pkg::*;
(
   input  logic [7:0] addr,
   output logic [7:0] data
);

   logic [7:0] rom [256];

   for (genvar i = 0; i < 256; i++) begin : g_rom
      localparam logic [7:0] ENTRY = gamma_entry(i);
      assign rom[i] = ENTRY;
   end

   assign data = rom[addr];

endmodule

// File: rtl/pixel_gamma_stage.sv
// Scan-out pixel conditioner: optional gamma (GAMMA_LUT_EN), then global brightness scale with frame-locked fade.
// Latency fixed at 2 cycles, one pixel per cycle, no stalls and no backpressure.
module pixel_gamma_stage
   import display_pkg::*;
#(
   parameter int CHANNEL_BITS = display_pkg::CHANNEL_BITS,
   parameter int BRIGHT_RESET = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [3*CHANNEL_BITS-1:0] pixel_in,
   input  logic                      frame_complete,
   input  logic                      bright_wr,
   input  logic [BRIGHT_BITS-1:0]    bright_target,
   input  logic [STEP_BITS-1:0]      bright_step,
   output logic                      out_valid,
   output logic [3*CHANNEL_BITS-1:0] pixel_out,
   output logic [BRIGHT_BITS-1:0]    bright_cur,
   output logic                      fading
);

   localparam int PB = 3 * CHANNEL_BITS;
   localparam int PW = CHANNEL_BITS + 8;

   // ---------------- fade control ----------------
   logic [BRIGHT_BITS-1:0] tgt_q;
   logic [STEP_BITS-1:0]   step_q;
   logic [0:0]             state_q;
   logic [BRIGHT_BITS-1:0] cur_nxt;
   logic [BRIGHT_BITS-1:0] tgt_nxt;
   logic [BRIGHT_BITS:0]   up_sum;
   logic [BRIGHT_BITS:0]   dn_diff;

   // Ninth bit catches overflow above 255 and underflow below 0.
   assign up_sum  = {1'b0, bright_cur} + {{(BRIGHT_BITS+1-STEP_BITS){1'b0}}, step_q};
   assign dn_diff = {1'b0, bright_cur} - {{(BRIGHT_BITS+1-STEP_BITS){1'b0}}, step_q};
   assign tgt_nxt = bright_wr ? bright_target : tgt_q;

   always_comb begin
      cur_nxt = bright_cur;
      case (state_q)
         FADE_RAMP: begin
            if (frame_complete) begin
               if (step_q == '0) begin
                  cur_nxt = tgt_q;
               end else if (bright_cur < tgt_q) begin
                  cur_nxt = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[BRIGHT_BITS-1:0];
               end else begin
                  cur_nxt = (dn_diff[BRIGHT_BITS] || (dn_diff[BRIGHT_BITS-1:0] <= tgt_q))
                          ? tgt_q : dn_diff[BRIGHT_BITS-1:0];
               end
            end
         end
         default: cur_nxt = bright_cur;
      endcase
   end

   // The step above uses the old target/step; a same-cycle write only affects later frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         bright_cur <= BRIGHT_BITS'(BRIGHT_RESET);
         tgt_q      <= BRIGHT_BITS'(BRIGHT_RESET);
         step_q     <= '0;
         state_q    <= FADE_IDLE;
      end else begin
         bright_cur <= cur_nxt;
         tgt_q      <= tgt_nxt;
         if (bright_wr) begin
            step_q <= bright_step;
         end
         state_q    <= (cur_nxt != tgt_nxt) ? FADE_RAMP : FADE_IDLE;
      end
   end

   assign fading = (state_q == FADE_RAMP);

   // ---------------- stage 1: gamma or plain register ----------------
   logic          valid1;
   logic [PB-1:0] pix1;
   logic [PB-1:0] c1_nxt;

   for (genvar ch = 0; ch < 3; ch++) begin : g_stage1
`ifdef GAMMA_LUT_EN
      gamma_lut u_gamma (
         .addr (pixel_in[ch*CHANNEL_BITS +: CHANNEL_BITS]),
         .data (c1_nxt[ch*CHANNEL_BITS +: CHANNEL_BITS])
      );
`else
      assign c1_nxt[ch*CHANNEL_BITS +: CHANNEL_BITS] = pixel_in[ch*CHANNEL_BITS +: CHANNEL_BITS];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid1 <= 1'b0;
         pix1   <= '0;
      end else begin
         valid1 <= in_valid;
         if (in_valid) begin
            pix1 <= c1_nxt;
         end
      end
   end

   // ---------------- stage 2: brightness scale ----------------
   logic [BRIGHT_BITS:0] bright_mul;
   logic [PB-1:0]        scaled;

   assign bright_mul = {1'b0, bright_cur} + 1'b1;

   // Multiplying by (b+1) then dropping 8 bits makes 255 exact identity and 0 fully black.
   for (genvar ch = 0; ch < 3; ch++) begin : g_stage2
      logic [PW-1:0] prod;
      assign prod = PW'(pix1[ch*CHANNEL_BITS +: CHANNEL_BITS]) * PW'(bright_mul);
      assign scaled[ch*CHANNEL_BITS +: CHANNEL_BITS] = CHANNEL_BITS'(prod >> 8);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         pixel_out <= '0;
      end else begin
         out_valid <= valid1;
         if (valid1) begin
            pixel_out <= scaled;
         end
      end
   end

endmodule
